posit_encoder: RTL and testbench

// - Packs an unpacked posit (sign, scale, fraction, sticky, specials) into a WIDTH-bit posit word.
// - Applies round-to-nearest-even and saturates to maxpos/minpos.
// - Serves as the output/packing end of the posit datapath: ALU cores (adder, multiplier)

---
 rtl/posit_pkg.sv | 36 +++
 rtl/posit_round_pack.sv | 87 ++++++++
 rtl/posit_encoder.sv | 131 +++++++++++++
 tb/tb_posit_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit datapath definitions: default format, the unpacked-result type
// and helpers for the special encodings.
package posit_pkg;

  localparam int POSIT_WIDTH = 32;
  localparam int POSIT_EN    = 3;
  localparam int POSIT_FW    = 32;

  // Signed scale width: enough for the exponent field plus the regime range, plus sign.
  function automatic int posit_sw(input int width, input int es);
    return es + $clog2(width) + 1;
  endfunction

  localparam int POSIT_SW = posit_sw(POSIT_WIDTH, POSIT_EN);

  // Unpacked posit as emitted by the arithmetic cores.
  typedef struct packed {
    logic                       nar;
    logic                       zero;
    logic                       sign;
    logic signed [POSIT_SW-1:0] scale;
    logic [POSIT_FW-1:0]        frac;
    logic                       sticky;
  } posit_unpacked_t;

  // Largest positive posit: 0 followed by all ones (returned in 64 bits, caller slices).
  function automatic logic [63:0] posit_maxpos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // NaR: only the sign bit set.
  function automatic logic [63:0] posit_nar(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/posit_round_pack.sv
// Combinational regime placement, round-to-nearest-even and sign application.
// Consumes a pre-clamped regime value k and exponent e; shared with the adder.
module posit_round_pack
  import posit_pkg::*;
#(
  parameter int WIDTH = POSIT_WIDTH,
  parameter int EN    = POSIT_EN,
  parameter int FW    = POSIT_FW,
  parameter int KW    = POSIT_SW - POSIT_EN
) (
  input  logic             nar,
  input  logic             zero,
  input  logic             sign,
  input  logic             sat_hi,
  input  logic             sat_lo,
  input  logic [KW-1:0]    k,
  input  logic [EN-1:0]    e,
  input  logic [FW-1:0]    frac,
  input  logic             sticky,
  output logic [WIDTH-1:0] q
);

  // Magnitude bits of the word, and the width of the aligned bit string.
  localparam int MW = WIDTH - 1;
  localparam int XW = WIDTH + 2 + EN + FW;

  localparam logic [63:0]      MAXPOS64 = posit_maxpos(WIDTH);
  localparam logic [63:0]      NAR64    = posit_nar(WIDTH);
  localparam logic [WIDTH-1:0] MAXPOS   = MAXPOS64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] NAR_WORD = NAR64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MINPOS   = WIDTH'(1);

  logic                 k_neg;
  logic [KW-1:0]        shamt;
  logic [XW-1:0]        field;
  logic signed [XW-1:0] shifted;
  logic [MW-1:0]        mag;
  logic                 guard;
  logic                 sticky_all;
  logic                 round_up;
  logic [WIDTH-1:0]     mag_sum;
  logic [MW-1:0]        mag_rnd;
  logic [WIDTH-1:0]     word;

  // Build the regime by sign-extending shift: "10" >>> k yields k+1 ones then a
  // zero, "01" >> (-k-1) yields -k zeros then a one. Exponent and fraction bits
  // ride along, so truncated exponent bits land in guard/sticky like fraction bits.
  always_comb begin
    k_neg      = k[KW-1];
    shamt      = k_neg ? ~k : k;
    field      = {(k_neg ? 2'b01 : 2'b10), e, frac, {WIDTH{1'b0}}};
    shifted    = $signed(field) >>> shamt;
    mag        = shifted[XW-1 -: MW];
    guard      = shifted[XW-1-MW];
    sticky_all = (|shifted[XW-2-MW:0]) | sticky;
  end

  // Round to nearest even; never round to zero and never wrap past maxpos.
  always_comb begin
    round_up = guard & (mag[0] | sticky_all);
    mag_sum  = {1'b0, mag} + {{MW{1'b0}}, round_up};
    if (mag_sum[WIDTH-1]) begin
      mag_rnd = MAXPOS[MW-1:0];
    end else if (mag_sum[MW-1:0] == '0) begin
      mag_rnd = MINPOS[MW-1:0];
    end else begin
      mag_rnd = mag_sum[MW-1:0];
    end
    word = {1'b0, mag_rnd};
  end

  // Special values take priority over the rounded encoding; negatives are two's complement.
  always_comb begin
    if (nar) begin
      q = NAR_WORD;
    end else if (zero) begin
      q = '0;
    end else if (sat_hi) begin
      q = sign ? -MAXPOS : MAXPOS;
    end else if (sat_lo) begin
      q = sign ? -MINPOS : MINPOS;
    end else begin
      q = sign ? -word : word;
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage posit packer: stage 1 clamps the scale and splits it into regime and
// exponent, stage 2 rounds and packs into q. Valid/ready on both sides.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int WIDTH = POSIT_WIDTH,
  parameter int EN    = POSIT_EN,
  parameter int FW    = POSIT_FW,
  localparam int SW   = posit_sw(WIDTH, EN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_nar,
  input  logic                 in_zero,
  input  logic                 in_sign,
  input  logic signed [SW-1:0] in_scale,
  input  logic [FW-1:0]        in_frac,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     q
);

  localparam int KW = SW - EN;
  // Largest representable scale: regime of WIDTH-1 ones, no exponent bits left.
  localparam logic signed [SW-1:0] MAXSCALE = SW'((WIDTH - 2) << EN);

  typedef struct packed {
    logic          nar;
    logic          zero;
    logic          sign;
    logic          sat_hi;
    logic          sat_lo;
    logic [KW-1:0] k;
    logic [EN-1:0] e;
    logic [FW-1:0] frac;
    logic          sticky;
  } stage1_t;

  stage1_t              s1_q, s1_d, s1_calc;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     pack_q;
  logic                 advance;
  logic                 sat_hi, sat_lo;
  logic signed [SW-1:0] scale_clamped;

  // The whole pipeline moves together whenever the output slot is free or being taken.
  assign advance   = !s2_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = s2_valid_q;
  assign q         = q_q;

  // Stage-1 arithmetic: saturation flags, clamp, split into regime k and exponent e.
  always_comb begin
    s1_calc = '0;
    sat_hi  = in_scale > MAXSCALE;
    sat_lo  = in_scale < -MAXSCALE;
    if (sat_hi) begin
      scale_clamped = MAXSCALE;
    end else if (sat_lo) begin
      scale_clamped = -MAXSCALE;
    end else begin
      scale_clamped = in_scale;
    end
    s1_calc.nar    = in_nar;
    s1_calc.zero   = in_zero;
    s1_calc.sign   = in_sign;
    s1_calc.sat_hi = sat_hi;
    s1_calc.sat_lo = sat_lo;
    s1_calc.k      = scale_clamped[SW-1:EN];
    s1_calc.e      = scale_clamped[EN-1:0];
    s1_calc.frac   = in_frac;
    s1_calc.sticky = in_sticky;
  end

  posit_round_pack #(
    .WIDTH (WIDTH),
    .EN    (EN),
    .FW    (FW),
    .KW    (KW)
  ) u_round_pack (
    .nar    (s1_q.nar),
    .zero   (s1_q.zero),
    .sign   (s1_q.sign),
    .sat_hi (s1_q.sat_hi),
    .sat_lo (s1_q.sat_lo),
    .k      (s1_q.k),
    .e      (s1_q.e),
    .frac   (s1_q.frac),
    .sticky (s1_q.sticky),
    .q      (pack_q)
  );

  // Next-state for both stages: hold everything on stall, otherwise shift forward.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    q_d        = q_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = s1_calc;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        q_d = pack_q;
      end
    end
  end

  // Pipeline registers; reset drops any words in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      q_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      q_q        <= q_d;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder: the driver pushes expected words, the
// monitor pops them as the DUT hands words off.
module tb_posit_encoder;

  localparam int WIDTH = 32;
  localparam int EN    = 3;
  localparam int FW    = 32;
  localparam int SW    = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_nar = 1'b0;
  logic                 in_zero = 1'b0;
  logic                 in_sign = 1'b0;
  logic signed [SW-1:0] in_scale = '0;
  logic [FW-1:0]        in_frac = '0;
  logic                 in_sticky = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [WIDTH-1:0]     q;

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    bit          exact;
  } sb_t;

  sb_t         exp_q[$];
  sb_t         ent;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          rcnt = 0;
  bit          hold_prev = 0;
  logic [31:0] prev_q = '0;

  posit_encoder #(.WIDTH(WIDTH), .EN(EN), .FW(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nar    (in_nar),
    .in_zero   (in_zero),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference: lay out regime, exponent and fraction as a plain bit list, keep the
  // first WIDTH-1 bits, round to nearest even on the rest.
  function automatic logic [31:0] ref_enc(input bit nar, input bit zero, input bit sign,
                                          input int scale, input logic [31:0] frac,
                                          input bit sticky);
    bit          bits[$];
    int          k;
    int          e;
    longint      mag;
    bit          guard;
    bit          st;
    logic [31:0] w;
    if (nar) return 32'h80000000;
    if (zero) return 32'h00000000;
    if (scale > 240) return sign ? 32'h80000001 : 32'h7FFFFFFF;
    if (scale < -240) return sign ? 32'hFFFFFFFF : 32'h00000001;
    k = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
    e = scale - k * 8;
    if (k >= 0) begin
      repeat (k + 1) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      repeat (-k) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
    for (int i = 31; i >= 0; i--) bits.push_back(frac[i]);
    mag = 0;
    for (int i = 0; i < 31; i++) mag = (mag << 1) | longint'((i < bits.size()) ? bits[i] : 1'b0);
    guard = (bits.size() > 31) ? bits[31] : 1'b0;
    st = sticky;
    for (int i = 32; i < bits.size(); i++) st = st | bits[i];
    if (guard && (mag[0] || st)) mag++;
    if (mag > 64'h7FFFFFFF) mag = 64'h7FFFFFFF;
    if (mag == 0) mag = 1;
    w = mag[31:0];
    return sign ? -w : w;
  endfunction

  // Downstream ready generator: always, 1,0,0,1 pattern, or random.
  always @(posedge clk) begin
    #1;
    rcnt = rcnt + 1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: handshake rule, stall stability, and in-order scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_term", 32'(in_ready), 32'(!out_valid | out_ready));
      if (hold_prev) begin
        check("stall_q_hold", q, prev_q);
        check("stall_valid_hold", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          ent = exp_q.pop_front();
          check("q_value", q, ent.exp);
          if (ent.exact) check("latency", 32'(cyc - ent.cyc), 32'd2);
          if (q === ent.exp) $display("txn out q=0x%08h lat=%0d", q, cyc - ent.cyc);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_q    = q;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Present one word, wait (bounded) for acceptance, record its expected encoding.
  task automatic send(input bit nar, input bit zero, input bit sign, input int scale,
                      input logic [31:0] frac, input bit sticky,
                      input bit use_exp, input logic [31:0] exp);
    int  w;
    sb_t s;
    in_valid  = 1'b1;
    in_nar    = nar;
    in_zero   = zero;
    in_sign   = sign;
    in_scale  = SW'(scale);
    in_frac   = frac;
    in_sticky = sticky;
    for (w = 0; w < 100; w++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    if (w == 100) begin
      check("accept_timeout", 32'(w), 32'd0);
    end else begin
      s.exp   = use_exp ? exp : ref_enc(nar, zero, sign, scale, frac, sticky);
      s.cyc   = cyc;
      s.exact = (ready_mode == 0);
      $display("txn in  scale=%0d frac=0x%08h sign=%0d exp=0x%08h", scale, frac, sign, s.exp);
      exp_q.push_back(s);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    int sc;
    sc = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(230, 250)) * ($urandom_range(0, 1) ? 1 : -1)
                                       : int'($urandom_range(0, 511)) - 256;
    send(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
         sc, $urandom(), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_q", q, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed encodings
    send(0, 0, 0, 0,    32'h00000000, 0, 1, 32'h40000000);
    send(0, 0, 0, 1,    32'h00000000, 0, 1, 32'h44000000);
    send(0, 0, 0, 8,    32'h00000000, 0, 1, 32'h60000000);
    send(0, 0, 1, 0,    32'h00000000, 0, 1, 32'hC0000000);
    send(0, 0, 0, 0,    32'h80000000, 0, 1, 32'h42000000);
    send(1, 0, 0, 5,    32'h12345678, 1, 1, 32'h80000000);
    send(0, 1, 1, 5,    32'h12345678, 1, 1, 32'h00000000);
    send(1, 1, 0, 0,    32'h00000000, 0, 1, 32'h80000000);
    send(0, 0, 0, 0,    32'h00000020, 0, 1, 32'h40000000);
    send(0, 0, 0, 0,    32'h00000020, 1, 1, 32'h40000001);
    send(0, 0, 0, 0,    32'h00000060, 0, 1, 32'h40000002);
    send(0, 0, 0, 250,  32'h00000000, 0, 1, 32'h7FFFFFFF);
    send(0, 0, 0, -250, 32'h00000000, 0, 1, 32'h00000001);
    send(0, 0, 1, -250, 32'h00000000, 0, 1, 32'hFFFFFFFF);
    send(0, 0, 0, 240,  32'hFFFFFFFF, 1, 1, 32'h7FFFFFFF);
    send(0, 0, 0, -240, 32'h00000000, 0, 1, 32'h00000001);
    send(0, 0, 1, 241,  32'h00000000, 0, 1, 32'h80000001);
    drain();

    // Back-to-back stream with out_ready cycling 1,0,0,1
    ready_mode = 1;
    repeat (8) send_rand();
    drain();

    // Random traffic with random backpressure and idle gaps
    ready_mode = 2;
    repeat (150) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Reset with two words in flight: both must be dropped
    send(0, 0, 0, 1, 32'h0, 0, 1, 32'h44000000);
    send(0, 0, 1, 8, 32'h0, 0, 1, 32'hA0000000);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_q", q, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(0, 0, 0, 0, 32'h80000000, 0, 1, 32'h42000000);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
